// File: rtl/riscv_bus_if.sv
// Bus bundle between the RV32I core, the bus unit and external memory.
// The slave modport is the bus unit's view; master is the core/memory side.
`timescale 1ns/1ps
interface riscv_bus_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_ready;
   logic [31:0]           if_rdata;
   logic                  if_err;

   logic                  ls_req;
   logic                  ls_we;
   logic [ADDR_WIDTH-1:0] ls_addr;
   logic [1:0]            ls_len;
   logic                  ls_sign;
   logic [31:0]           ls_wdata;
   logic                  ls_ready;
   logic [31:0]           ls_rdata;
   logic                  ls_err;

   logic                  mem_valid;
   logic                  mem_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [3:0]            mem_wstrb;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_ready, if_rdata, if_err,
      input  ls_req, ls_we, ls_addr, ls_len, ls_sign, ls_wdata,
      output ls_ready, ls_rdata, ls_err,
      output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_ready, if_rdata, if_err,
      output ls_req, ls_we, ls_addr, ls_len, ls_sign, ls_wdata,
      input  ls_ready, ls_rdata, ls_err,
      input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/riscv_bus_unit.sv
// Fetch/load-store arbiter with valid/ready memory handshake, lane alignment and extension.
// Define BUS_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES wait states.
`timescale 1ns/1ps
module riscv_bus_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic        clk,
   input logic        reset,
   riscv_bus_if.slave bus
);

   // state  | meaning
   // S_IDLE | sample requests, load/store wins over fetch
   // S_BUSY | memory cycle outstanding, mem_* held until mem_ready
   // S_RESP | one-cycle ready pulse to the selected requester
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

   state_e                state_q, state_d;
   logic                  src_ls_q, src_ls_d;
   logic                  we_q, we_d;
   logic                  sign_q, sign_d;
   logic [1:0]            len_q, len_d;
   logic [1:0]            lane_q, lane_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]            mem_wstrb_q, mem_wstrb_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic                  ls_mis, if_mis;
   logic [3:0]            req_wstrb;
   logic [31:0]           req_wdata;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [31:0]           load_data;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   assign ls_mis = ((bus.ls_len == 2'd1) && bus.ls_addr[0]) ||
                   (bus.ls_len[1] && (bus.ls_addr[1:0] != 2'b00));
   assign if_mis = (bus.if_addr[1:0] != 2'b00);

   always_comb begin
      req_wstrb = 4'b1111;
      req_wdata = bus.ls_wdata;
      case (bus.ls_len)
         2'd0: begin
            req_wstrb = 4'b0001 << bus.ls_addr[1:0];
            req_wdata = {4{bus.ls_wdata[7:0]}};
         end
         2'd1: begin
            req_wstrb = bus.ls_addr[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{bus.ls_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel = bus.mem_rdata[7:0];
      case (lane_q)
         2'd1:    byte_sel = bus.mem_rdata[15:8];
         2'd2:    byte_sel = bus.mem_rdata[23:16];
         2'd3:    byte_sel = bus.mem_rdata[31:24];
         default: ;
      endcase
      half_sel  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      load_data = bus.mem_rdata;
      case (len_q)
         2'd0:    load_data = {{24{sign_q & byte_sel[7]}}, byte_sel};
         2'd1:    load_data = {{16{sign_q & half_sel[15]}}, half_sel};
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      src_ls_d    = src_ls_q;
      we_d        = we_q;
      sign_d      = sign_q;
      len_d       = len_q;
      lane_d      = lane_q;
      mem_valid_d = mem_valid_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.ls_req) begin
               src_ls_d = 1'b1;
               we_d     = bus.ls_we;
               sign_d   = bus.ls_sign;
               len_d    = bus.ls_len;
               lane_d   = bus.ls_addr[1:0];
               rdata_d  = '0;
               err_d    = ls_mis;
               if (ls_mis) begin
                  state_d = S_RESP;
               end else begin
                  state_d     = S_BUSY;
                  mem_valid_d = 1'b1;
                  mem_we_d    = bus.ls_we;
                  mem_addr_d  = {bus.ls_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wstrb_d = bus.ls_we ? req_wstrb : 4'b0000;
                  mem_wdata_d = bus.ls_we ? req_wdata : 32'd0;
               end
            end else if (bus.if_req) begin
               src_ls_d = 1'b0;
               we_d     = 1'b0;
               sign_d   = 1'b0;
               len_d    = 2'd2;
               lane_d   = bus.if_addr[1:0];
               rdata_d  = '0;
               err_d    = if_mis;
               if (if_mis) begin
                  state_d = S_RESP;
               end else begin
                  state_d     = S_BUSY;
                  mem_valid_d = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = {bus.if_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wstrb_d = 4'b0000;
                  mem_wdata_d = 32'd0;
               end
            end
`ifdef BUS_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         S_BUSY: begin
            // A completion in the same cycle as the wait limit takes precedence.
            if (mem_valid_q && bus.mem_ready) begin
               state_d     = S_RESP;
               rdata_d     = we_q ? 32'd0 : load_data;
               err_d       = 1'b0;
               mem_valid_d = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wstrb_d = 4'b0000;
               mem_wdata_d = 32'd0;
            end
`ifdef BUS_TIMEOUT_EN
            else if (cnt_q == TO_LIMIT) begin
               state_d     = S_RESP;
               rdata_d     = 32'd0;
               err_d       = 1'b1;
               mem_valid_d = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wstrb_d = 4'b0000;
               mem_wdata_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TO_LIMIT) begin
                  mem_valid_d = 1'b0;
                  mem_we_d    = 1'b0;
                  mem_wstrb_d = 4'b0000;
               end
            end
`endif
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         src_ls_q    <= 1'b0;
         we_q        <= 1'b0;
         sign_q      <= 1'b0;
         len_q       <= 2'd0;
         lane_q      <= 2'd0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wstrb_q <= 4'b0000;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         src_ls_q    <= src_ls_d;
         we_q        <= we_d;
         sign_q      <= sign_d;
         len_q       <= len_d;
         lane_q      <= lane_d;
         mem_valid_q <= mem_valid_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   logic resp_ls, resp_if;
   assign resp_ls = (state_q == S_RESP) && src_ls_q;
   assign resp_if = (state_q == S_RESP) && !src_ls_q;

   assign bus.ls_ready  = resp_ls;
   assign bus.ls_rdata  = resp_ls ? rdata_q : 32'd0;
   assign bus.ls_err    = resp_ls & err_q;
   assign bus.if_ready  = resp_if;
   assign bus.if_rdata  = resp_if ? rdata_q : 32'd0;
   assign bus.if_err    = resp_if & err_q;

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_riscv_bus_unit.sv
// Self-checking bench for riscv_bus_unit: directed cases plus randomized accesses
// checked against an arithmetic reference model of alignment, extension and latency.
`timescale 1ns/1ps
module tb_riscv_bus_unit;
   localparam int AW = 32;
   localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   riscv_bus_if #(.ADDR_WIDTH(AW)) bus ();

   riscv_bus_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] len,
                                            input logic [31:0] addr, input bit sign);
      logic [31:0] v;
      if (len == 2'd0) begin
         v = (d >> (8 * (addr % 4))) % 256;
         if (sign && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (len == 2'd1) begin
         v = (d >> (16 * ((addr / 2) % 2))) % 65536;
         if (sign && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_strb(input logic [1:0] len, input logic [31:0] addr);
      if (len == 2'd0) return 4'(1 << (addr % 4));
      if (len == 2'd1) return ((addr / 2) % 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] len, input logic [31:0] w);
      if (len == 2'd0) return (w % 256) * 32'h0101_0101;
      if (len == 2'd1) return (w % 65536) * 32'h0001_0001;
      return w;
   endfunction

   task automatic clear_inputs();
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_len = 2'd0;
      bus.ls_sign = 1'b0; bus.ls_wdata = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
   endtask

   // Drives one request, plays memory with the given wait states, checks every cycle.
   task automatic run_xfer(input bit is_ls, input bit we, input logic [31:0] addr,
                           input logic [1:0] len, input bit sign, input logic [31:0] wdata,
                           input int waits, input logic [31:0] mdata, input string name);
      bit          mis, timed, exp_err, got, rdy, other, exp_valid;
      int          busy_last, exp_k;
      logic [31:0] exp_rd, act_rd;
      logic        act_err;
      mis = is_ls ? ((len == 2'd1 && (addr % 2) != 0) || (len >= 2'd2 && (addr % 4) != 0))
                  : ((addr % 4) != 0);
      timed     = TIMEOUT_ON && !mis && (waits >= TO);
      busy_last = mis ? 0 : (timed ? TO : waits + 1);
      exp_k     = mis ? 1 : (timed ? TO + 2 : waits + 2);
      exp_err   = mis || timed;
      exp_rd    = (exp_err || (is_ls && we)) ? 32'd0 :
                  (is_ls ? ref_load(mdata, len, addr, sign) : mdata);
      got = 1'b0;

      @(negedge clk);
      if (is_ls) begin
         bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = addr; bus.ls_len = len;
         bus.ls_sign = sign; bus.ls_wdata = wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      bus.mem_ready = 1'b0;
      bus.mem_rdata = mdata;
      @(posedge clk);

      for (int k = 1; k <= exp_k + 20; k++) begin
         @(negedge clk);
         exp_valid = (k <= busy_last);
         n_tests++;
         if (bus.mem_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL %s mem_valid cycle %0d: got %b want %b", name, k, bus.mem_valid, exp_valid);
         end
         if (bus.mem_valid === 1'b1) begin
            n_tests++;
            if (bus.mem_addr !== (addr / 4) * 4 || bus.mem_we !== (is_ls && we) ||
                bus.mem_wstrb !== ((is_ls && we) ? ref_strb(len, addr) : 4'd0)) begin
               n_fail++;
               $display("FAIL %s mem_cmd: addr %h we %b strb %b want addr %h we %b strb %b", name,
                        bus.mem_addr, bus.mem_we, bus.mem_wstrb, (addr / 4) * 4, (is_ls && we),
                        (is_ls && we) ? ref_strb(len, addr) : 4'd0);
            end
            if (is_ls && we) begin
               n_tests++;
               if (bus.mem_wdata !== ref_wdata(len, wdata)) begin
                  n_fail++;
                  $display("FAIL %s mem_wdata: got %h want %h", name, bus.mem_wdata, ref_wdata(len, wdata));
               end
            end
         end
         rdy     = is_ls ? bus.ls_ready : bus.if_ready;
         other   = is_ls ? bus.if_ready : bus.ls_ready;
         act_rd  = is_ls ? bus.ls_rdata : bus.if_rdata;
         act_err = is_ls ? bus.ls_err : bus.if_err;
         n_tests++;
         if (other !== 1'b0) begin
            n_fail++;
            $display("FAIL %s other_ready cycle %0d: got %b want 0", name, k, other);
         end
         if (rdy === 1'b1) begin
            n_tests++;
            if (k != exp_k) begin
               n_fail++;
               $display("FAIL %s latency: ready at N+%0d want N+%0d", name, k, exp_k);
            end
            n_tests++;
            if (act_rd !== exp_rd || act_err !== exp_err) begin
               n_fail++;
               $display("FAIL %s response: rdata %h err %b want rdata %h err %b", name,
                        act_rd, act_err, exp_rd, exp_err);
            end
            if (is_ls) bus.ls_req = 1'b0; else bus.if_req = 1'b0;
            got = 1'b1;
            break;
         end else begin
            n_tests++;
            if (act_rd !== 32'd0 || act_err !== 1'b0) begin
               n_fail++;
               $display("FAIL %s idle_resp cycle %0d: rdata %h err %b want 0 0", name, k, act_rd, act_err);
            end
         end
         bus.mem_ready = !mis && (k == waits + 1);
      end
      bus.mem_ready = 1'b0;
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s no_ready: got none want ready at N+%0d", name, exp_k);
         bus.ls_req = 1'b0;
         bus.if_req = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [31:0] agg;
      clear_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      agg = bus.if_rdata | bus.ls_rdata | bus.mem_wdata | bus.mem_addr |
            {21'd0, bus.if_ready, bus.if_err, bus.ls_ready, bus.ls_err,
             bus.mem_valid, bus.mem_we, bus.mem_wstrb, 1'b0};
      n_tests++;
      if (agg !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: or-of-outputs %h want 0", agg);
      end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      run_xfer(1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'd0, 0, 32'h00A0_0093, "fetch");
      run_xfer(1'b0, 1'b0, 32'h2000, 2'd2, 1'b0, 32'd0, 2, 32'hDEAD_BEEF, "fetch_wait");
   endtask

   task automatic test_load();
      run_xfer(1'b1, 1'b0, 32'h203, 2'd0, 1'b1, 32'd0, 3, 32'h8011_2233, "lb_sign");
      run_xfer(1'b1, 1'b0, 32'h203, 2'd0, 1'b0, 32'd0, 3, 32'h8011_2233, "lbu");
      run_xfer(1'b1, 1'b0, 32'h202, 2'd1, 1'b1, 32'd0, 1, 32'h8011_2233, "lh_sign");
      run_xfer(1'b1, 1'b0, 32'h200, 2'd3, 1'b0, 32'd0, 0, 32'hCAFE_F00D, "lw_len3");
   endtask

   task automatic test_store();
      run_xfer(1'b1, 1'b1, 32'h302, 2'd1, 1'b0, 32'h0000_BEEF, 0, 32'h1234_5678, "sh");
      run_xfer(1'b1, 1'b1, 32'h305, 2'd0, 1'b0, 32'h0000_00A5, 1, 32'h1234_5678, "sb");
      run_xfer(1'b1, 1'b1, 32'h308, 2'd2, 1'b0, 32'h0BAD_CAFE, 2, 32'h1234_5678, "sw");
   endtask

   task automatic test_misaligned();
      run_xfer(1'b1, 1'b0, 32'h401, 2'd2, 1'b0, 32'd0, 0, 32'h1111_1111, "mis_lw");
      run_xfer(1'b1, 1'b0, 32'h403, 2'd1, 1'b1, 32'd0, 0, 32'h1111_1111, "mis_lh");
      run_xfer(1'b1, 1'b1, 32'h402, 2'd3, 1'b0, 32'h55, 0, 32'h1111_1111, "mis_sw");
      run_xfer(1'b0, 1'b0, 32'h102, 2'd2, 1'b0, 32'd0, 0, 32'h1111_1111, "mis_fetch");
   endtask

   task automatic test_random();
      bit          is_ls, we, sign;
      logic [1:0]  len;
      logic [31:0] addr;
      for (int i = 0; i < 40; i++) begin
         is_ls = ($urandom_range(0, 4) != 0);
         we    = $urandom_range(0, 1);
         sign  = $urandom_range(0, 1);
         len   = 2'($urandom_range(0, 3));
         addr  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (!is_ls || len >= 2'd2) addr = addr & 32'hFFFF_FFFC;
            else if (len == 2'd1)      addr = addr & 32'hFFFF_FFFE;
         end
         run_xfer(is_ls, we, addr, len, sign, $urandom, $urandom_range(0, 3), $urandom, "random");
      end
   endtask

   task automatic test_back_to_back();
      int n_ls, n_if, k_ls, k_if;
      n_ls = 0; n_if = 0; k_ls = 0; k_if = 0;
      @(negedge clk);
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h400; bus.ls_len = 2'd2;
      bus.if_req = 1'b1; bus.if_addr = 32'h500;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n_tests++;
         if (bus.mem_valid !== (k == 1 || k == 4)) begin
            n_fail++;
            $display("FAIL arb mem_valid cycle %0d: got %b want %b", k, bus.mem_valid, (k == 1 || k == 4));
         end
         if (bus.mem_valid === 1'b1) begin
            n_tests++;
            if (bus.mem_addr !== ((k == 1) ? 32'h400 : 32'h500)) begin
               n_fail++;
               $display("FAIL arb mem_addr cycle %0d: got %h want %h", k, bus.mem_addr,
                        (k == 1) ? 32'h400 : 32'h500);
            end
         end
         if (bus.ls_ready === 1'b1) begin
            n_ls++; k_ls = k; bus.ls_req = 1'b0;
         end
         if (bus.if_ready === 1'b1) begin
            n_if++; k_if = k; bus.if_req = 1'b0;
            n_tests++;
            if (bus.if_rdata !== 32'h1234_5678) begin
               n_fail++;
               $display("FAIL arb if_rdata: got %h want 12345678", bus.if_rdata);
            end
         end
      end
      bus.mem_ready = 1'b0;
      bus.ls_req = 1'b0;
      bus.if_req = 1'b0;
      n_tests++;
      if (n_ls != 1 || n_if != 1) begin
         n_fail++;
         $display("FAIL arb pulses: ls %0d if %0d want 1 1", n_ls, n_if);
      end
      n_tests++;
      if (k_ls != 2 || k_if != 5) begin
         n_fail++;
         $display("FAIL arb order: ls at %0d if at %0d want 2 5", k_ls, k_if);
      end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h600; bus.ls_len = 2'd2;
      bus.ls_wdata = 32'h7777_7777; bus.mem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.mem_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_busy pre: mem_valid %b want 1", bus.mem_valid);
      end
      @(negedge clk);
      reset = 1'b1;
      bus.ls_req = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.mem_valid !== 1'b0 || bus.mem_wstrb !== 4'd0 || bus.ls_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_busy abort: mem_valid %b wstrb %b ls_ready %b want 0 0 0",
                  bus.mem_valid, bus.mem_wstrb, bus.ls_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      run_xfer(1'b1, 1'b0, 32'h604, 2'd2, 1'b0, 32'd0, 0, 32'h0F0F_0F0F, "after_reset");
   endtask

   task automatic test_timeout();
`ifdef BUS_TIMEOUT_EN
      run_xfer(1'b1, 1'b0, 32'h700, 2'd2, 1'b0, 32'd0, 1000, 32'hAAAA_5555, "timeout_stuck");
      run_xfer(1'b1, 1'b0, 32'h704, 2'd2, 1'b0, 32'd0, TO - 1, 32'hAAAA_5555, "timeout_edge_win");
      run_xfer(1'b0, 1'b0, 32'h708, 2'd2, 1'b0, 32'd0, TO, 32'hAAAA_5555, "timeout_fetch");
`endif
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_misaligned();
      test_back_to_back();
      test_reset_busy();
      test_timeout();
      test_random();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
